adc_frame_packer: RTL and testbench

//  Multi-channel successor to the single-channel 8-bit ADC->FIFO->UDP capture path.

---
 rtl/adc_frame_packer.sv | 258 +++++++++++++++++++++++++
 tb/tb_adc_frame_packer.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_frame_packer.sv
// rtl/adc_frame_packer.sv - multi-channel ADC frame packer with ping-pong banks feeding the udp tx engine (optional header: FRAME_SEQ_HDR_EN)
module adc_frame_packer #(
  parameter int CH_NUM        = 2,
  parameter int SAMPLE_W      = 10,
  parameter int FRAME_SAMPLES = 256
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       capture_en,
  input  logic                       one_shot,
  input  logic                       smp_valid,
  input  logic [CH_NUM*SAMPLE_W-1:0] smp_data,
  output logic                       tx_start_en,
  output logic [15:0]                tx_byte_num,
  input  logic                       tx_req,
  output logic [7:0]                 tx_data,
  input  logic                       tx_done,
  output logic [15:0]                drop_cnt,
  output logic                       busy
);
  localparam int BPS       = (SAMPLE_W <= 8) ? 1 : 2;
  localparam int SET_BYTES = CH_NUM * BPS;
  localparam int SET_W     = 8 * SET_BYTES;
  localparam int AW        = $clog2(FRAME_SAMPLES);
`ifdef FRAME_SEQ_HDR_EN
  localparam int HDR = 4;
`else
  localparam int HDR = 0;
`endif
  localparam logic [15:0]   BYTE_NUM_C = 16'(HDR + FRAME_SAMPLES * SET_BYTES);
  localparam logic [AW-1:0] LAST_SET   = AW'(FRAME_SAMPLES - 1);
  localparam logic [2:0]    LAST_BYTE  = 3'(SET_BYTES - 1);

  typedef enum logic [1:0] {B_FREE, B_FILL, B_READY, B_SEND} bank_e;
  typedef enum logic [1:0] {S_IDLE, S_START, S_SEND, S_WAIT} rd_e;

  bank_e         bank_q [2];
  bank_e         bank_d [2];
  rd_e           state_q, state_d;
  logic          wr_has_q, wr_has_d;
  logic          wr_bank_q, wr_bank_d;
  logic          wr_pref_q, wr_pref_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic          older_q, older_d;
  logic          halt_q, halt_d;
  logic          cap_prev_q, cap_prev_d;
  logic [15:0]   drop_q, drop_d;
  logic          rd_bank_q, rd_bank_d;
  logic [15:0]   rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] rd_set_q, rd_set_d;
  logic [2:0]    rd_byte_q, rd_byte_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic [15:0]   byte_num_q, byte_num_d;
`ifdef FRAME_SEQ_HDR_EN
  logic [15:0]   seq_q, seq_d;
`endif

  logic [SET_W-1:0] mem_q [2*FRAME_SAMPLES];
  logic [SET_W-1:0] wr_word, rd_word;
  logic [AW:0]      wr_addr;
  logic             wr_en, take, wb, cap_ok, in_hdr;
  logic [AW-1:0]    wp;
  logic [7:0]       hdr_byte;

  // A whole sample set is stored as one RAM word with byte k of the set at bits [8k+:8].
  for (genvar c = 0; c < CH_NUM; c++) begin : g_pack
    if (BPS == 2) begin : g_two
      logic [15:0] ext;
      assign ext = 16'(smp_data[c*SAMPLE_W +: SAMPLE_W]);
      assign wr_word[16*c +: 16] = {ext[7:0], ext[15:8]};
    end else begin : g_one
      assign wr_word[8*c +: 8] = 8'(smp_data[c*SAMPLE_W +: SAMPLE_W]);
    end
  end

  assign rd_word = mem_q[{rd_bank_q, rd_set_q}];

  // Reader FSM first so a bank freed by tx_done is visible to the writer in the same cycle.
  always_comb begin
    bank_d     = bank_q;
    state_d    = state_q;
    rd_bank_d  = rd_bank_q;
    rd_ptr_d   = rd_ptr_q;
    rd_set_d   = rd_set_q;
    rd_byte_d  = rd_byte_q;
    tx_data_d  = tx_data_q;
    wr_has_d   = wr_has_q;
    wr_bank_d  = wr_bank_q;
    wr_pref_d  = wr_pref_q;
    wr_ptr_d   = wr_ptr_q;
    older_d    = older_q;
    halt_d     = halt_q;
    cap_prev_d = capture_en;
    drop_d     = drop_q;
    byte_num_d = BYTE_NUM_C;
    wr_en      = 1'b0;
    wr_addr    = '0;
    take       = 1'b0;
    wb         = wr_bank_q;
    wp         = wr_ptr_q;
`ifdef FRAME_SEQ_HDR_EN
    seq_d  = seq_q;
    in_hdr = (rd_ptr_q < 16'(HDR));
    case (rd_ptr_q[1:0])
      2'd0:    hdr_byte = 8'hA5;
      2'd1:    hdr_byte = 8'(CH_NUM);
      2'd2:    hdr_byte = seq_q[15:8];
      default: hdr_byte = seq_q[7:0];
    endcase
`else
    in_hdr   = 1'b0;
    hdr_byte = 8'h00;
`endif

    case (state_q)
      S_IDLE: begin
        if (bank_q[0] == B_READY || bank_q[1] == B_READY) begin
          rd_bank_d          = (bank_q[older_q] == B_READY) ? older_q : ~older_q;
          bank_d[rd_bank_d]  = B_SEND;
          rd_ptr_d           = '0;
          rd_set_d           = '0;
          rd_byte_d          = '0;
          state_d            = S_START;
        end
      end
      S_START: state_d = S_SEND;
      S_SEND: begin
        if (tx_req) begin
          rd_ptr_d = rd_ptr_q + 16'd1;
          if (in_hdr) begin
            tx_data_d = hdr_byte;
          end else begin
            tx_data_d = rd_word[{rd_byte_q, 3'b000} +: 8];
            if (rd_byte_q == LAST_BYTE) begin
              rd_byte_d = '0;
              rd_set_d  = rd_set_q + AW'(1);
            end else begin
              rd_byte_d = rd_byte_q + 3'd1;
            end
          end
          if (rd_ptr_q == BYTE_NUM_C - 16'd1) state_d = S_WAIT;
        end
      end
      default: begin
        if (tx_done) begin
          bank_d[rd_bank_q] = B_FREE;
          state_d           = S_IDLE;
`ifdef FRAME_SEQ_HDR_EN
          seq_d = seq_q + 16'd1;
`endif
        end
      end
    endcase

    // After a one-shot halt only a fresh capture_en rising edge lets samples in again.
    if (capture_en && !cap_prev_q) halt_d = 1'b0;
    cap_ok = capture_en && (!halt_q || !cap_prev_q);

    if (!capture_en) begin
      if (wr_has_q) begin
        bank_d[wr_bank_q] = B_FREE;
        wr_has_d          = 1'b0;
        wr_ptr_d          = '0;
        wr_pref_d         = wr_bank_q;
      end
    end else if (smp_valid && cap_ok) begin
      take = 1'b1;
      if (wr_has_q) begin
        wb = wr_bank_q;
        wp = wr_ptr_q;
      end else if (bank_d[wr_pref_q] == B_FREE) begin
        wb = wr_pref_q;
        wp = '0;
      end else if (bank_d[~wr_pref_q] == B_FREE) begin
        wb = ~wr_pref_q;
        wp = '0;
      end else begin
        take = 1'b0;
      end
      if (take) begin
        wr_en   = 1'b1;
        wr_addr = {wb, wp};
        if (wp == LAST_SET) begin
          bank_d[wb] = B_READY;
          wr_has_d   = 1'b0;
          wr_ptr_d   = '0;
          wr_pref_d  = ~wb;
          older_d    = (bank_d[~wb] == B_READY) ? ~wb : wb;
          if (one_shot) halt_d = 1'b1;
        end else begin
          bank_d[wb] = B_FILL;
          wr_has_d   = 1'b1;
          wr_bank_d  = wb;
          wr_ptr_d   = wp + AW'(1);
        end
      end else if (drop_q != 16'hFFFF) begin
        drop_d = drop_q + 16'd1;
      end
    end
  end

  // Sample RAM: one write port (whole set), read data registered through tx_data_q.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_addr] <= wr_word;
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      bank_q[0]  <= B_FREE;
      bank_q[1]  <= B_FREE;
      state_q    <= S_IDLE;
      wr_has_q   <= 1'b0;
      wr_bank_q  <= 1'b0;
      wr_pref_q  <= 1'b0;
      wr_ptr_q   <= '0;
      older_q    <= 1'b0;
      halt_q     <= 1'b0;
      cap_prev_q <= 1'b0;
      drop_q     <= '0;
      rd_bank_q  <= 1'b0;
      rd_ptr_q   <= '0;
      rd_set_q   <= '0;
      rd_byte_q  <= '0;
      tx_data_q  <= '0;
      byte_num_q <= '0;
`ifdef FRAME_SEQ_HDR_EN
      seq_q      <= '0;
`endif
    end else begin
      bank_q     <= bank_d;
      state_q    <= state_d;
      wr_has_q   <= wr_has_d;
      wr_bank_q  <= wr_bank_d;
      wr_pref_q  <= wr_pref_d;
      wr_ptr_q   <= wr_ptr_d;
      older_q    <= older_d;
      halt_q     <= halt_d;
      cap_prev_q <= cap_prev_d;
      drop_q     <= drop_d;
      rd_bank_q  <= rd_bank_d;
      rd_ptr_q   <= rd_ptr_d;
      rd_set_q   <= rd_set_d;
      rd_byte_q  <= rd_byte_d;
      tx_data_q  <= tx_data_d;
      byte_num_q <= byte_num_d;
`ifdef FRAME_SEQ_HDR_EN
      seq_q      <= seq_d;
`endif
    end
  end

  assign tx_start_en = (state_q == S_START);
  assign tx_byte_num = byte_num_q;
  assign tx_data     = tx_data_q;
  assign drop_cnt    = drop_q;
  assign busy        = wr_has_q || bank_q[0] == B_READY || bank_q[1] == B_READY || state_q != S_IDLE;
endmodule

// File: tb/tb_adc_frame_packer.sv
// tb/tb_adc_frame_packer.sv - table-driven scoreboard bench for adc_frame_packer
module tb_adc_frame_packer;
`ifdef FRAME_SEQ_HDR_EN
  localparam int HDR = 4;
`else
  localparam int HDR = 0;
`endif
  localparam logic [15:0] EXP_BYTES = 16'(HDR + 16);

  logic        clk = 1'b0, rst = 1'b1, capture_en = 1'b0, one_shot = 1'b0;
  logic        smp_valid = 1'b0, tx_req = 1'b0, tx_done = 1'b0;
  logic [19:0] smp_data = '0;
  logic        tx_start_en, busy;
  logic [15:0] tx_byte_num, drop_cnt;
  logic [7:0]  tx_data;

  adc_frame_packer #(.CH_NUM(2), .SAMPLE_W(10), .FRAME_SAMPLES(4)) dut (
    .clk(clk), .rst(rst), .capture_en(capture_en), .one_shot(one_shot),
    .smp_valid(smp_valid), .smp_data(smp_data), .tx_start_en(tx_start_en),
    .tx_byte_num(tx_byte_num), .tx_req(tx_req), .tx_data(tx_data),
    .tx_done(tx_done), .drop_cnt(drop_cnt), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [9:0]  ch0;
    logic [9:0]  ch1;
    logic [31:0] exp;
  } vec_t;

  vec_t       vecs [8];
  logic [7:0] exp_q [$];
  logic [7:0] last_byte = 8'h00;
  int         n_checks = 0, n_pass = 0;
  int         start_cnt = 0, starts_used = 0;
  int         frames_model = 0, set_in_frame = 0;

  always @(negedge clk) if (tx_start_en) start_cnt++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_set(input int i);
    logic [31:0] w;
    logic [15:0] s;
    if (set_in_frame == 0 && HDR != 0) begin
      s = 16'(frames_model);
      exp_q.push_back(8'hA5);
      exp_q.push_back(8'h02);
      exp_q.push_back(s[15:8]);
      exp_q.push_back(s[7:0]);
    end
    if (set_in_frame == 0) frames_model++;
    w = vecs[i].exp;
    exp_q.push_back(w[31:24]);
    exp_q.push_back(w[23:16]);
    exp_q.push_back(w[15:8]);
    exp_q.push_back(w[7:0]);
    set_in_frame = (set_in_frame + 1) % 4;
  endtask

  task automatic feed(input int i, input bit capt);
    smp_data  = {vecs[i % 8].ch1, vecs[i % 8].ch0};
    smp_valid = 1'b1;
    if (capt) push_set(i % 8);
    tick();
    smp_valid = 1'b0;
  endtask

  task automatic req_byte(input string name);
    logic [7:0] b;
    if ($urandom_range(0, 3) == 0) begin
      tx_req = 1'b0;
      tick();
      check({name, "_hold"}, tx_data, last_byte);
    end
    tx_req = 1'b1;
    tick();
    if (exp_q.size() == 0) begin
      check({name, "_sb_empty"}, 1, 0);
    end else begin
      b = exp_q.pop_front();
      check(name, tx_data, b);
      last_byte = b;
    end
  endtask

  task automatic wait_start(input string name, output bit ok);
    int n = 0;
    while (start_cnt <= starts_used && n < 50) begin
      tick();
      n++;
    end
    ok = (start_cnt > starts_used);
    check({name, "_start"}, ok, 1);
    starts_used = start_cnt;
  endtask

  task automatic send_frame(input string name, input bit done);
    bit ok;
    wait_start(name, ok);
    if (ok) begin
      for (int i = 0; i < int'(EXP_BYTES); i++) req_byte(name);
    end
    tx_req = 1'b0;
    if (done) begin
      tx_done = 1'b1;
      tick();
      tx_done = 1'b0;
    end
  endtask

  initial begin
    int base, n;
    vecs[0] = '{ch0: 10'h001, ch1: 10'h3FF, exp: 32'h000103FF};
    vecs[1] = '{ch0: 10'h002, ch1: 10'h200, exp: 32'h00020200};
    vecs[2] = '{ch0: 10'h155, ch1: 10'h0AA, exp: 32'h015500AA};
    vecs[3] = '{ch0: 10'h3FF, ch1: 10'h000, exp: 32'h03FF0000};
    vecs[4] = '{ch0: 10'h080, ch1: 10'h100, exp: 32'h00800100};
    vecs[5] = '{ch0: 10'h2A5, ch1: 10'h35A, exp: 32'h02A5035A};
    vecs[6] = '{ch0: 10'h0FF, ch1: 10'h301, exp: 32'h00FF0301};
    vecs[7] = '{ch0: 10'h123, ch1: 10'h321, exp: 32'h01230321};

    // reset state
    repeat (3) tick();
    check("rst_start", tx_start_en, 0);
    check("rst_data", tx_data, 0);
    check("rst_bytenum", tx_byte_num, 0);
    check("rst_drop", drop_cnt, 0);
    check("rst_busy", busy, 0);
    rst = 1'b0;
    tick();
    tick();
    check("bytenum", tx_byte_num, EXP_BYTES);
    tx_req = 1'b1;
    tick();
    tx_req = 1'b0;
    check("idle_req_ignored", tx_data, 0);

    // one frame, continuous mode
    capture_en = 1'b1;
    feed(0, 1);
    check("t1_busy_fill", busy, 1);
    for (int i = 1; i < 4; i++) feed(i, 1);
    n = 0;
    while (!tx_start_en && n < 20) begin
      tick();
      n++;
    end
    check("t1_start_seen", tx_start_en, 1);
    tick();
    check("t1_start_pulse", tx_start_en, 0);
    send_frame("t1_byte", 0);
    tx_req = 1'b1;
    tick();
    tx_req = 1'b0;
    check("t1_extra_req", tx_data, last_byte);
    check("t1_busy_wait", busy, 1);
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    tick();
    check("t1_busy_idle", busy, 0);
    check("t1_one_start", start_cnt, 1);

    // three frames back to back
    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < 4; i++) feed(4 * f + i + 4, 1);
      send_frame("t2_byte", 1);
    end
    tick();
    check("t2_starts", start_cnt, 4);

    // both banks busy: 4 fill A, 4 fill B, 4 dropped
    for (int i = 0; i < 12; i++) feed(i, i < 8);
    check("t3_drop", drop_cnt, 4);
    send_frame("t3_a", 0);
    repeat (3) tick();
    check("t3_no_start_in_wait", start_cnt, starts_used);
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    n = 0;
    while (!tx_start_en && n < 2) begin
      tick();
      n++;
    end
    check("t3_restart_latency", tx_start_en, 1);
    for (int i = 0; i < 4; i++) feed(i + 2, 1);
    send_frame("t3_b", 0);
    smp_data  = {vecs[6].ch1, vecs[6].ch0};
    smp_valid = 1'b1;
    tx_done   = 1'b1;
    push_set(6);
    tick();
    smp_valid = 1'b0;
    tx_done   = 1'b0;
    for (int i = 0; i < 3; i++) feed(i + 7, 1);
    check("t3_same_cycle_no_drop", drop_cnt, 4);
    send_frame("t3_c", 1);
    send_frame("t3_d", 1);
    repeat (3) tick();
    check("t3_busy_end", busy, 0);

    // one-shot halt and re-arm
    base = start_cnt;
    one_shot = 1'b1;
    for (int i = 0; i < 10; i++) feed(i + 3, i < 4);
    send_frame("t4_a", 1);
    repeat (6) tick();
    check("t4_one_frame", start_cnt - base, 1);
    capture_en = 1'b0;
    tick();
    capture_en = 1'b1;
    for (int i = 0; i < 6; i++) feed(i + 1, i < 4);
    send_frame("t4_b", 1);
    repeat (6) tick();
    check("t4_rearm_one_more", start_cnt - base, 2);
    check("t4_busy_halted", busy, 0);

    // capture_en dropped mid-frame
    capture_en = 1'b0;
    one_shot   = 1'b0;
    tick();
    capture_en = 1'b1;
    base = start_cnt;
    feed(0, 0);
    feed(1, 0);
    capture_en = 1'b0;
    tick();
    check("t5_busy_discard", busy, 0);
    repeat (4) tick();
    check("t5_no_start", start_cnt, base);
    capture_en = 1'b1;
    for (int i = 4; i < 8; i++) feed(i, 1);
    send_frame("t5_byte", 1);

    // reset in the middle of sending
    begin
      bit ok;
      for (int i = 0; i < 4; i++) feed(i + 5, 1);
      wait_start("t6", ok);
      for (int i = 0; i < 3; i++) req_byte("t6_part");
      tx_req = 1'b0;
    end
    rst = 1'b1;
    tick();
    check("t6_rst_start", tx_start_en, 0);
    check("t6_rst_data", tx_data, 0);
    check("t6_rst_bytenum", tx_byte_num, 0);
    check("t6_rst_drop", drop_cnt, 0);
    check("t6_rst_busy", busy, 0);
    exp_q.delete();
    frames_model = 0;
    set_in_frame = 0;
    last_byte    = 8'h00;
    rst = 1'b0;
    tick();
    starts_used = start_cnt;
    for (int i = 0; i < 4; i++) feed(i, 1);
    send_frame("t6_byte", 1);
    check("t6_sb_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
